// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter and its result buffer.
package wb_arbiter_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // A load is legal when its type exists and its address is naturally aligned
    function automatic logic loadIsLegal(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic legal;
        legal = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: legal = 1'b1;
            F3_LH, F3_LHU: legal = ~addrLo[0];
            F3_LW:         legal = (addrLo == 2'b00);
            default:       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries; exposes next-cycle slot contents so the
// parent can register a pending-destination mask in step with the buffer.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t pushEntry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o,
    output logic [4:0] nextRd_o [DEPTH],
    output logic       nextValid_o [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Next-state of storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d   = mem_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wrPtr_q] = pushEntry_i;
            wrPtr_d        = wrPtr_q + 1'b1;
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // A slot is occupied next cycle when its distance from the next read pointer is below the next count
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rdPtr_d;
            nextValid_o[i] = (CNT_W'(offset) < count_d);
            nextRd_o[i]    = mem_d[i].rd;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the never-stalled load path and the buffered ALU path
// into one registered regfile write per cycle, with load extension and x0 filtering.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int XLEN           = WB_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data,
    output logic            write,
    output logic [31:0]     pending_mask,
    output logic            misalign_err
);

    wb_entry_t       aluEntry;
    wb_entry_t       headEntry;
    logic            fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic [4:0]      slotRd [ALU_FIFO_DEPTH];
    logic            slotValid [ALU_FIFO_DEPTH];
    logic            aluFire;

    logic            outOfReset_q;
    logic            write_q, write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdData_q, rdData_d;
    logic            misalignErr_q, misalignErr_d;
    logic [31:0]     pendingMask_q, pendingMask_d;

    // Byte/half lane selection followed by sign or zero extension
    function automatic logic [XLEN-1:0] extractLoad(input logic [2:0] funct3,
                                                    input logic [1:0] addrLo,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]      byteVal;
        logic [15:0]     halfVal;
        logic [XLEN-1:0] result;
        byteVal = word[{addrLo, 3'b000} +: 8];
        halfVal = word[{addrLo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byteVal[7]}}, byteVal};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byteVal};
            F3_LH:   result = {{(XLEN-16){halfVal[15]}}, halfVal};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, halfVal};
            default: result = word;
        endcase
        return result;
    endfunction

    assign alu_ready = outOfReset_q & ~fifoFull;
    assign aluFire   = alu_valid & alu_ready;
    assign aluEntry  = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH(ALU_FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifoPush),
        .pushEntry_i(aluEntry),
        .pop_i      (fifoPop),
        .head_o     (headEntry),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .nextRd_o   (slotRd),
        .nextValid_o(slotValid)
    );

    // Arbitration: load first, then FIFO head, then an ALU result bypassing an idle FIFO
    always_comb begin
        write_d       = 1'b0;
        rd_d          = rd_q;
        rdData_d      = rdData_q;
        misalignErr_d = 1'b0;
        fifoPop       = 1'b0;
        fifoPush      = aluFire & (mem_valid | ~fifoEmpty);
        if (mem_valid) begin
            if (!loadIsLegal(mem_funct3, mem_addr_lo)) begin
                misalignErr_d = 1'b1;
            end else if (mem_rd != 5'd0) begin
                write_d  = 1'b1;
                rd_d     = mem_rd;
                rdData_d = extractLoad(mem_funct3, mem_addr_lo, mem_data);
            end
        end else if (!fifoEmpty) begin
            fifoPop = 1'b1;
            if (headEntry.rd != 5'd0) begin
                write_d  = 1'b1;
                rd_d     = headEntry.rd;
                rdData_d = headEntry.data;
            end
        end else if (aluFire) begin
            if (alu_rd != 5'd0) begin
                write_d  = 1'b1;
                rd_d     = alu_rd;
                rdData_d = alu_data;
            end
        end
    end

    // Pending mask follows what the buffer will hold after this edge; x0 never flagged
    always_comb begin
        pendingMask_d = '0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
            if (slotValid[i] && slotRd[i] != 5'd0) begin
                pendingMask_d[slotRd[i]] = 1'b1;
            end
        end
    end

    // Output and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outOfReset_q  <= 1'b0;
            write_q       <= 1'b0;
            rd_q          <= '0;
            rdData_q      <= '0;
            misalignErr_q <= 1'b0;
            pendingMask_q <= '0;
        end else begin
            outOfReset_q  <= 1'b1;
            write_q       <= write_d;
            rd_q          <= rd_d;
            rdData_q      <= rdData_d;
            misalignErr_q <= misalignErr_d;
            pendingMask_q <= pendingMask_d;
        end
    end

    assign write        = write_q;
    assign rd           = rd_q;
    assign rd_data      = rdData_q;
    assign misalign_err = misalignErr_q;
    assign pending_mask = pendingMask_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares whenever the DUT writes or flags an error.
module tb_wb_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        write;
    logic [31:0] pending_mask;
    logic        misalign_err;

    exp_t expQ[$];
    exp_t monE;
    int   expErrPending = 0;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter #(
        .ALU_FIFO_DEPTH(2),
        .XLEN(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .rd(rd), .rd_data(rd_data), .write(write),
        .pending_mask(pending_mask), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write or error pulse must match the next scoreboard expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (write) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_write unexpected actual rd=%0d data=%h required no write", rd, rd_data);
                end else begin
                    monE = expQ.pop_front();
                    if (rd !== monE.rd || rd_data !== monE.data) begin
                        errors++;
                        $display("[TB] FAIL sb_write actual rd=%0d data=%h required rd=%0d data=%h",
                                 rd, rd_data, monE.rd, monE.data);
                    end
                end
            end
            if (misalign_err) begin
                checks++;
                if (expErrPending == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_misalign unexpected actual=1 required=0");
                end else begin
                    expErrPending--;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rd   = r;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs, check alu_ready before the edge, return #1 after it
    task automatic applyStimulus(input logic memV, input logic [4:0] mRd, input logic [2:0] f3,
                                 input logic [1:0] lo, input logic [31:0] md,
                                 input logic aluV, input logic [4:0] aRd, input logic [31:0] aD,
                                 input logic expReady);
        mem_valid   = memV;
        mem_rd      = mRd;
        mem_funct3  = f3;
        mem_addr_lo = lo;
        mem_data    = md;
        alu_valid   = aluV;
        alu_rd      = aRd;
        alu_data    = aD;
        checkOutput("alu_ready", 32'(alu_ready), 32'(expReady));
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input logic expReady);
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0, expReady);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_funct3 = '0; mem_addr_lo = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        #1;
        checkOutput("rst_write", 32'(write), 32'd0);
        checkOutput("rst_ready", 32'(alu_ready), 32'd0);
        checkOutput("rst_mask", pending_mask, 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", 32'(alu_ready), 32'd1);

        // ALU only, idle FIFO: bypass with one-cycle latency
        expectWrite(5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        checkOutput("alu_write", 32'(write), 32'd1);
        checkOutput("alu_rd", 32'(rd), 32'd5);
        checkOutput("alu_data", rd_data, 32'hDEADBEEF);
        checkOutput("alu_mask", pending_mask, 32'd0);

        // Contention: load wins, ALU result waits one cycle in the FIFO
        expectWrite(5'd3, 32'h11223344);
        expectWrite(5'd7, 32'h0000000A);
        applyStimulus(1'b1, 5'd3, 3'b010, 2'd0, 32'h11223344, 1'b1, 5'd7, 32'hA, 1'b1);
        checkOutput("cont_rd1", 32'(rd), 32'd3);
        checkOutput("cont_mask1", pending_mask, 32'h00000080);
        idle(1'b1);
        checkOutput("cont_rd2", 32'(rd), 32'd7);
        checkOutput("cont_data2", rd_data, 32'hA);
        checkOutput("cont_mask2", pending_mask, 32'd0);

        // Load extension on 0x80FF7F01
        expectWrite(5'd8, 32'hFFFFFF80);
        applyStimulus(1'b1, 5'd8, 3'b000, 2'd3, 32'h80FF7F01, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("lb3", rd_data, 32'hFFFFFF80);
        expectWrite(5'd9, 32'h0000007F);
        applyStimulus(1'b1, 5'd9, 3'b100, 2'd1, 32'h80FF7F01, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("lbu1", rd_data, 32'h0000007F);
        expectWrite(5'd10, 32'hFFFF80FF);
        applyStimulus(1'b1, 5'd10, 3'b001, 2'd2, 32'h80FF7F01, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("lh2", rd_data, 32'hFFFF80FF);
        expectWrite(5'd11, 32'h00007F01);
        applyStimulus(1'b1, 5'd11, 3'b101, 2'd0, 32'h80FF7F01, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("lhu0", rd_data, 32'h00007F01);

        // Misaligned LW and an undefined funct3: one-cycle error pulse, no write
        expErrPending++;
        applyStimulus(1'b1, 5'd9, 3'b010, 2'd2, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("mis_err", 32'(misalign_err), 32'd1);
        checkOutput("mis_write", 32'(write), 32'd0);
        idle(1'b1);
        checkOutput("mis_pulse_end", 32'(misalign_err), 32'd0);
        expErrPending++;
        applyStimulus(1'b1, 5'd12, 3'b011, 2'd0, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("bad_f3_err", 32'(misalign_err), 32'd1);

        // ALU x0 on idle FIFO: consumed, no write, rd holds previous value
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b1, 5'd0, 32'h99, 1'b1);
        checkOutput("x0_write", 32'(write), 32'd0);
        checkOutput("x0_rd_hold", 32'(rd), 32'd11);

        // ALU x0 queued behind a load, then x6 queued behind it
        expectWrite(5'd4, 32'h55);
        applyStimulus(1'b1, 5'd4, 3'b010, 2'd0, 32'h55, 1'b1, 5'd0, 32'h99, 1'b1);
        checkOutput("x0q_mask", pending_mask, 32'd0);
        expectWrite(5'd6, 32'h66);
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1);
        checkOutput("x0q_pop_write", 32'(write), 32'd0);
        checkOutput("x0q_mask6", pending_mask, 32'h00000040);
        idle(1'b1);
        checkOutput("x0q_rd6", 32'(rd), 32'd6);

        // Back-pressure: four loads in a row, ALU stream stalls after two pushes
        expectWrite(5'd13, 32'h100);
        expectWrite(5'd14, 32'h200);
        expectWrite(5'd15, 32'h300);
        expectWrite(5'd16, 32'h400);
        expectWrite(5'd20, 32'hA1);
        expectWrite(5'd21, 32'hA2);
        expectWrite(5'd22, 32'hA3);
        applyStimulus(1'b1, 5'd13, 3'b010, 2'd0, 32'h100, 1'b1, 5'd20, 32'hA1, 1'b1);
        applyStimulus(1'b1, 5'd14, 3'b010, 2'd0, 32'h200, 1'b1, 5'd21, 32'hA2, 1'b1);
        checkOutput("bp_mask_full", pending_mask, 32'h00300000);
        applyStimulus(1'b1, 5'd15, 3'b010, 2'd0, 32'h300, 1'b1, 5'd22, 32'hA3, 1'b0);
        applyStimulus(1'b1, 5'd16, 3'b010, 2'd0, 32'h400, 1'b1, 5'd22, 32'hA3, 1'b0);
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b1, 5'd22, 32'hA3, 1'b0);
        applyStimulus(1'b0, 5'd0, 3'b010, 2'd0, 32'h0, 1'b1, 5'd22, 32'hA3, 1'b1);
        checkOutput("bp_mask_a3", pending_mask, 32'h00400000);
        idle(1'b1);
        checkOutput("bp_mask_drained", pending_mask, 32'd0);
        idle(1'b1);

        // Reset mid-traffic with two ALU entries queued
        expectWrite(5'd1, 32'h1111);
        applyStimulus(1'b1, 5'd1, 3'b010, 2'd0, 32'h1111, 1'b1, 5'd17, 32'h10, 1'b1);
        applyStimulus(1'b1, 5'd2, 3'b010, 2'd0, 32'h2222, 1'b1, 5'd18, 32'h11, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_write", 32'(write), 32'd0);
        checkOutput("mrst_mask", pending_mask, 32'd0);
        checkOutput("mrst_ready", 32'(alu_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mrst_ready_after", 32'(alu_ready), 32'd1);
        checkOutput("mrst_write_after", 32'(write), 32'd0);
        checkOutput("mrst_mask_after", pending_mask, 32'd0);
        repeat (3) idle(1'b1);

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 20 && (expQ.size() != 0 || expErrPending != 0); i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("sb_remaining_writes", 32'(expQ.size()), 32'd0);
        checkOutput("sb_remaining_errs", 32'(expErrPending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
